// File: rtl/seq_mag_comparator_pkg.sv
// Shared types and elaboration helpers for the sequential magnitude comparator.
package seq_mag_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of SLICE-bit digits in a WIDTH-bit operand.
    function automatic int unsigned nsl(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

    function automatic bit width_ok(input int unsigned width, input int unsigned slice);
        return (slice != 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/seq_mag_comparator_digit_cmp.sv
// Combinational SLICE-bit digit compare; invert_msb flips the top bit of both
// digits so the most significant digit orders as two's complement.
module seq_mag_comparator_digit_cmp #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             invert_msb,
    output logic             gt_c,
    output logic             lt_c
);

    logic [SLICE-1:0] flip;
    logic [SLICE-1:0] a_adj;
    logic [SLICE-1:0] b_adj;

    assign flip  = SLICE'(invert_msb) << (SLICE - 1);
    assign a_adj = a ^ flip;
    assign b_adj = b ^ flip;
    assign gt_c  = a_adj > b_adj;
    assign lt_c  = a_adj < b_adj;

endmodule

// File: rtl/seq_mag_comparator.sv
// Digit-serial MSB-first magnitude comparator with early exit, start/busy/done
// handshake, registered results and a saturating equal-result counter.
module seq_mag_comparator
    import seq_mag_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic [CNT_W-1:0] eq_count
);

    localparam int unsigned NSL   = nsl(WIDTH, SLICE);
    localparam int unsigned IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (!width_ok(WIDTH, SLICE)) begin : g_width_check
        $error("seq_mag_comparator: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic [IDX_W-1:0] idx;
    logic [SLICE-1:0] a_digit;
    logic [SLICE-1:0] b_digit;
    logic             dig_gt_c;
    logic             dig_lt_c;
    logic             load_c;
    logic             finish_c;

    assign a_digit  = SLICE'(a_q >> (SLICE * 32'(idx)));
    assign b_digit  = SLICE'(b_q >> (SLICE * 32'(idx)));
    assign load_c   = start && (state != CMP);
    assign finish_c = (state == CMP) && (state_next == DONE);

    seq_mag_comparator_digit_cmp #(
        .SLICE (SLICE)
    ) u_digit_cmp (
        .a          (a_digit),
        .b          (b_digit),
        .invert_msb (signed_q && (idx == IDX_TOP)),
        .gt_c       (dig_gt_c),
        .lt_c       (dig_lt_c)
    );

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CMP;
            CMP:  if (dig_gt_c || dig_lt_c || (idx == '0)) state_next = DONE;
            DONE: state_next = start ? CMP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lt       <= 1'b0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            max_out  <= '0;
            min_out  <= '0;
            eq_count <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == CMP);
            done  <= (state_next == DONE);
            if (load_c) begin
                a_q      <= in_a;
                b_q      <= in_b;
                signed_q <= signed_mode;
                idx      <= IDX_TOP;
            end else if ((state == CMP) && (state_next == CMP)) begin
                idx <= idx - IDX_W'(1);
            end
            // Results only move on the CMP->DONE transition and hold otherwise
            if (finish_c) begin
                gt      <= dig_gt_c;
                lt      <= dig_lt_c;
                eq      <= !(dig_gt_c || dig_lt_c);
                max_out <= dig_lt_c ? b_q : a_q;
                min_out <= dig_lt_c ? a_q : b_q;
                if (!(dig_gt_c || dig_lt_c) && (eq_count != CNT_MAX)) begin
                    eq_count <= eq_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
